// File: rtl/axi_lite_cmd_master.sv
// Single-outstanding AXI4-Lite master: converts a valid/ready command stream into
// AXI-Lite write/read transactions and returns one response per command.
module axi_lite_cmd_master #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16,
    localparam int STRB_W = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    // command stream
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    input  logic [STRB_W-1:0] cmd_wstrb,
    // response stream
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_write,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [1:0]        rsp_resp,
    // AXI write address / data / response
    output logic [ADDR_W-1:0] awaddr,
    output logic              awvalid,
    input  logic              awready,
    output logic [DATA_W-1:0] wdata,
    output logic [STRB_W-1:0] wstrb,
    output logic              wvalid,
    input  logic              wready,
    input  logic [1:0]        bresp,
    input  logic              bvalid,
    output logic              bready,
    // AXI read address / data
    output logic [ADDR_W-1:0] araddr,
    output logic              arvalid,
    input  logic              arready,
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        rresp,
    input  logic              rvalid,
    output logic              rready,
    // debug
    output logic              busy,
    output logic [CNT_W-1:0]  txn_count,
    output logic [CNT_W-1:0]  err_count
);

    typedef enum logic [2:0] {IDLE, WR, WR_B, RD_A, RD_R, RSP} state_t;

    state_t state;
    logic   aw_done;
    logic   w_done;
    logic   aw_hs;
    logic   w_hs;

    assign aw_hs = awvalid && awready;
    assign w_hs  = wvalid && wready;

    // Gated by rst so no command is taken while reset is asserted.
    assign cmd_ready = (state == IDLE) && !rst;

    // NOTE: every register here uses non-blocking assignment so all state updates
    // see pre-edge values; blocking assignment would make ordering matter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            awaddr    <= '0;
            awvalid   <= 1'b0;
            wdata     <= '0;
            wstrb     <= '0;
            wvalid    <= 1'b0;
            bready    <= 1'b0;
            araddr    <= '0;
            arvalid   <= 1'b0;
            rready    <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_write <= 1'b0;
            rsp_rdata <= '0;
            rsp_resp  <= 2'b00;
            busy      <= 1'b0;
            txn_count <= '0;
            err_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        busy <= 1'b1;
                        if (cmd_write) begin
                            awaddr  <= cmd_addr;
                            wdata   <= cmd_wdata;
                            wstrb   <= cmd_wstrb;
                            awvalid <= 1'b1;
                            wvalid  <= 1'b1;
                            state   <= WR;
                        end else begin
                            araddr  <= cmd_addr;
                            arvalid <= 1'b1;
                            state   <= RD_A;
                        end
                    end
                end
                WR: begin
                    // AW and W complete independently, in either order or together.
                    if (aw_hs) begin
                        awvalid <= 1'b0;
                        aw_done <= 1'b1;
                    end
                    if (w_hs) begin
                        wvalid <= 1'b0;
                        w_done <= 1'b1;
                    end
                    if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                        bready  <= 1'b1;
                        state   <= WR_B;
                    end
                end
                WR_B: begin
                    if (bvalid && bready) begin
                        bready    <= 1'b0;
                        rsp_write <= 1'b1;
                        rsp_rdata <= '0;
                        rsp_resp  <= bresp;
                        rsp_valid <= 1'b1;
                        state     <= RSP;
                    end
                end
                RD_A: begin
                    if (arvalid && arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        state   <= RD_R;
                    end
                end
                RD_R: begin
                    if (rvalid && rready) begin
                        rready    <= 1'b0;
                        rsp_write <= 1'b0;
                        rsp_rdata <= rdata;
                        rsp_resp  <= rresp;
                        rsp_valid <= 1'b1;
                        state     <= RSP;
                    end
                end
                RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                        if (txn_count != '1) txn_count <= txn_count + 1'b1;
                        if (rsp_resp != 2'b00 && err_count != '1) err_count <= err_count + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// Self-checking bench: a 4-register AXI-Lite slave with programmable stalls, and a
// queue-based response model checked against the DUT every cycle.
module tb_axi_lite_cmd_master;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int STRB_W  = 4;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cmd_valid, cmd_ready, cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic [STRB_W-1:0] cmd_wstrb;
    logic              rsp_valid, rsp_ready, rsp_write;
    logic [DATA_W-1:0] rsp_rdata;
    logic [1:0]        rsp_resp;
    logic [ADDR_W-1:0] awaddr, araddr;
    logic              awvalid, awready, wvalid, wready, bvalid, bready;
    logic              arvalid, arready, rvalid, rready;
    logic [DATA_W-1:0] wdata, rdata;
    logic [STRB_W-1:0] wstrb;
    logic [1:0]        bresp, rresp;
    logic              busy;
    logic [CNT_W-1:0]  txn_count, err_count;

    axi_lite_cmd_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .busy(busy), .txn_count(txn_count), .err_count(err_count)
    );

    always #5 clk = ~clk;

    int npass = 0;
    int ntot  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    endtask

    // Slave decodes four words at 0x0..0xC; anything else is SLVERR.
    function automatic logic addr_ok(input logic [31:0] a);
        return (a < 32'h10) && (a[1:0] == 2'b00);
    endfunction

    // ---------------- bench slave ----------------
    logic [31:0] sregs [4] = '{default: 32'h0};
    int   aw_dly, w_dly, b_dly, ar_dly, r_dly;
    logic early_b;
    int   aw_wait = 0, w_wait = 0, b_wait = 0, ar_wait = 0, r_wait = 0, last_w_wait = 0;
    logic aw_got = 1'b0, w_got = 1'b0, ar_got = 1'b0;
    logic [31:0] s_awaddr = 0, s_wdata = 0, s_araddr = 0;
    logic [3:0]  s_wstrb = 0;
    int   n_aw = 0, n_w = 0, n_ar = 0, n_b = 0;

    assign awready = awvalid && (aw_wait >= aw_dly);
    assign wready  = wvalid && (w_wait >= w_dly);
    assign bvalid  = (aw_got && w_got && (b_wait >= b_dly)) || (early_b && (awvalid || aw_got));
    assign bresp   = addr_ok(s_awaddr) ? 2'b00 : 2'b10;
    assign arready = arvalid && (ar_wait >= ar_dly);
    assign rvalid  = ar_got && (r_wait >= r_dly);
    assign rdata   = addr_ok(s_araddr) ? sregs[s_araddr[3:2]] : 32'hDEADBEEF;
    assign rresp   = addr_ok(s_araddr) ? 2'b00 : 2'b10;

    always @(posedge clk) begin
        if (rst) begin
            aw_got <= 1'b0; w_got <= 1'b0; ar_got <= 1'b0;
            aw_wait <= 0; w_wait <= 0; b_wait <= 0; ar_wait <= 0; r_wait <= 0;
        end else begin
            if (awvalid && !awready) aw_wait <= aw_wait + 1;
            if (awvalid && awready) begin
                aw_wait <= 0; aw_got <= 1'b1; s_awaddr <= awaddr; n_aw <= n_aw + 1;
            end
            if (wvalid && !wready) w_wait <= w_wait + 1;
            if (wvalid && wready) begin
                last_w_wait <= w_wait; w_wait <= 0; w_got <= 1'b1;
                s_wdata <= wdata; s_wstrb <= wstrb; n_w <= n_w + 1;
            end
            if (aw_got && w_got && !bvalid) b_wait <= b_wait + 1;
            if (bvalid && bready) begin
                aw_got <= 1'b0; w_got <= 1'b0; b_wait <= 0; n_b <= n_b + 1;
                if (addr_ok(s_awaddr))
                    for (int b = 0; b < 4; b++)
                        if (s_wstrb[b]) sregs[s_awaddr[3:2]][8*b +: 8] <= s_wdata[8*b +: 8];
            end
            if (arvalid && !arready) ar_wait <= ar_wait + 1;
            if (arvalid && arready) begin
                ar_wait <= 0; ar_got <= 1'b1; s_araddr <= araddr; n_ar <= n_ar + 1;
            end
            if (ar_got && !rvalid) r_wait <= r_wait + 1;
            if (rvalid && rready) begin
                ar_got <= 1'b0; r_wait <= 0;
            end
        end
    end

    // ---------------- reference model ----------------
    typedef struct packed {
        logic        w;
        logic [31:0] rdata;
        logic [1:0]  resp;
    } rsp_t;

    rsp_t        exp_q[$];
    logic [31:0] mregs [4] = '{default: 32'h0};
    int   cyc = 0, acc_cyc = 0, last_lat = 0, last_space = 0;
    int   m_txn = 0, m_err = 0, n_rsp = 0, n_wr_cmd = 0, n_rd_cmd = 0;
    logic outst = 1'b0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            exp_q.delete();
            outst <= 1'b0; m_txn <= 0; m_err <= 0;
        end else begin
            if (cmd_valid && cmd_ready) begin
                check("single_outstanding", outst, 0);
                if (cmd_write) begin
                    exp_q.push_back(rsp_t'{1'b1, 32'h0, addr_ok(cmd_addr) ? 2'b00 : 2'b10});
                    if (addr_ok(cmd_addr))
                        for (int b = 0; b < 4; b++)
                            if (cmd_wstrb[b]) mregs[cmd_addr[3:2]][8*b +: 8] <= cmd_wdata[8*b +: 8];
                    n_wr_cmd <= n_wr_cmd + 1;
                end else begin
                    exp_q.push_back(rsp_t'{1'b0,
                        addr_ok(cmd_addr) ? mregs[cmd_addr[3:2]] : 32'hDEADBEEF,
                        addr_ok(cmd_addr) ? 2'b00 : 2'b10});
                    n_rd_cmd <= n_rd_cmd + 1;
                end
                outst <= 1'b1; last_space <= cyc - acc_cyc; acc_cyc <= cyc;
            end
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) check("unexpected_rsp", 0, 1);
                else begin
                    m_txn <= (m_txn == CNT_MAX) ? CNT_MAX : m_txn + 1;
                    if (exp_q[0].resp != 2'b00) m_err <= (m_err == CNT_MAX) ? CNT_MAX : m_err + 1;
                    void'(exp_q.pop_front());
                end
                outst <= 1'b0; last_lat <= cyc - acc_cyc; n_rsp <= n_rsp + 1;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    logic        p_awv = 0, p_awr = 0, p_wv = 0, p_wr = 0, p_arv = 0, p_arr = 0;
    logic [31:0] p_awaddr = 0, p_wdata = 0, p_araddr = 0;
    logic [3:0]  p_wstrb = 0;

    always @(negedge clk) begin
        if (!rst) begin
            check("busy", busy, outst);
            check("cmd_ready", cmd_ready, !outst);
            check("txn_count", txn_count, m_txn);
            check("err_count", err_count, m_err);
            if (rsp_valid) begin
                if (exp_q.size() == 0) check("rsp_without_cmd", 0, 1);
                else begin
                    check("rsp_write", rsp_write, exp_q[0].w);
                    check("rsp_rdata", rsp_rdata, exp_q[0].rdata);
                    check("rsp_resp", rsp_resp, exp_q[0].resp);
                end
            end
            if (p_awv && !p_awr) check("aw_hold", {awvalid, awaddr}, {1'b1, p_awaddr});
            if (p_wv && !p_wr) check("w_hold", {wvalid, wstrb, wdata}, {1'b1, p_wstrb, p_wdata});
            if (p_arv && !p_arr) check("ar_hold", {arvalid, araddr}, {1'b1, p_araddr});
            if (bready) check("bready_after_aw_w", {aw_got, w_got}, 2'b11);
        end
        p_awv <= awvalid; p_awr <= awready; p_awaddr <= awaddr;
        p_wv <= wvalid; p_wr <= wready; p_wdata <= wdata; p_wstrb <= wstrb;
        p_arv <= arvalid; p_arr <= arready; p_araddr <= araddr;
    end

    // ---------------- stimulus ----------------
    task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        bit ok = 0;
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                @(posedge clk); #1;
                ok = 1;
            end
        end
        if (!ok) check("cmd_accept_timeout", 0, 1);
        cmd_valid = 1'b0;
    endtask

    task automatic get_rsp(input int stall, output logic w, output logic [31:0] d, output logic [1:0] r);
        bit ok = 0;
        int st = stall;
        w = 1'bx; d = 'x; r = 'x;
        rsp_ready = (st == 0);
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                if (st > 0) st--;
                else begin
                    rsp_ready = 1'b1;
                    w = rsp_write; d = rsp_rdata; r = rsp_resp;
                    @(posedge clk); #1;
                    ok = 1;
                end
            end
        end
        if (!ok) check("rsp_timeout", 0, 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic        w;
        logic [31:0] d;
        logic [1:0]  r;
        int          base;

        cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0; rsp_ready = 0;
        aw_dly = 0; w_dly = 0; b_dly = 0; ar_dly = 0; r_dly = 0; early_b = 0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_ctrl", {awvalid, wvalid, bready, arvalid, rready, rsp_valid, rsp_write, busy, cmd_ready}, 0);
        check("reset_addr", {awaddr, araddr}, 0);
        check("reset_data", {wdata, rsp_rdata}, 0);
        check("reset_misc", {wstrb, rsp_resp, txn_count, err_count}, 0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("cmd_ready_after_reset", cmd_ready, 1);
        @(posedge clk); #1;

        // single write, zero-wait slave
        send(1'b1, 32'h0, 32'hA5A50000, 4'hF);
        get_rsp(0, w, d, r);
        check("t1_latency", last_lat, 3);
        check("t1_rsp_write", w, 1);
        check("t1_resp", r, 0);
        check("t1_aw_count", n_aw, 1);
        check("t1_w_count", n_w, 1);
        check("t1_txn", txn_count, 1);

        // fill the remaining registers, then read all back-to-back
        for (int i = 1; i < 4; i++) begin
            send(1'b1, 32'(4 * i), 32'hA5A50000 + 32'(i), 4'hF);
            get_rsp(0, w, d, r);
        end
        for (int i = 0; i < 4; i++) begin
            send(1'b0, 32'(4 * i), 32'h0, 4'h0);
            if (i > 0) check("b2b_spacing", last_space, 4);
            get_rsp(0, w, d, r);
            check("t2_rdata", d, 32'hA5A50000 + 32'(i));
            check("t2_rsp_write", w, 0);
        end
        check("t2_txn", txn_count, 8);
        check("t2_err", err_count, 0);

        // W lags AW by three cycles while the slave raises bvalid early
        aw_dly = 0; w_dly = 3; early_b = 1;
        base = n_rsp;
        send(1'b1, 32'h4, 32'h12345678, 4'b0011);
        get_rsp(0, w, d, r);
        check("t3_w_stall", last_w_wait, 3);
        check("t3_one_rsp", n_rsp - base, 1);
        check("t3_one_b", n_b, 5);
        check("t3_resp", r, 0);
        w_dly = 0; early_b = 0;

        // invalid address read
        send(1'b0, 32'h20, 32'h0, 4'h0);
        get_rsp(0, w, d, r);
        check("t4_rdata", d, 32'hDEADBEEF);
        check("t4_resp", r, 2);
        check("t4_err", err_count, 1);

        // response stall with a pending command
        send(1'b0, 32'h4, 32'h0, 4'h0);
        base = n_wr_cmd;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'hC; cmd_wdata = 32'hCAFEF00D; cmd_wstrb = 4'hF;
        get_rsp(5, w, d, r);
        check("t5_rdata", d, 32'hA5A55678);
        check("t5_not_accepted", n_wr_cmd, base);
        send(1'b1, 32'hC, 32'hCAFEF00D, 4'hF);
        get_rsp(0, w, d, r);
        check("t5_write_resp", {w, r}, 3'b100);

        // randomized traffic; enough errors and transactions to saturate both counters
        for (int k = 0; k < 80; k++) begin
            int pick;
            logic [31:0] a;
            aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3); b_dly = $urandom_range(0, 3);
            ar_dly = $urandom_range(0, 3); r_dly = $urandom_range(0, 3); early_b = 1'($urandom_range(0, 1));
            pick = $urandom_range(0, 9);
            if (pick < 5)      a = 32'(4 * $urandom_range(0, 3));
            else if (pick < 9) a = 32'(4 * $urandom_range(4, 15));
            else               a = 32'(4 * $urandom_range(0, 3) + 1);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            send(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)));
            get_rsp($urandom_range(0, 3), w, d, r);
        end
        check("txn_saturated", txn_count, CNT_MAX);
        check("rsp_total", n_rsp, n_wr_cmd + n_rd_cmd);
        check("aw_per_write", n_aw, n_wr_cmd);
        check("w_per_write", n_w, n_wr_cmd);
        check("ar_per_read", n_ar, n_rd_cmd);

        // reset while waiting for read data
        aw_dly = 0; w_dly = 0; b_dly = 0; ar_dly = 0; r_dly = 50; early_b = 0;
        send(1'b0, 32'h0, 32'h0, 4'h0);
        repeat (3) @(negedge clk);
        check("in_rd_r", {rready, rvalid}, 2'b10);
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        check("rst_abandon", {arvalid, rready, rsp_valid, busy, cmd_ready}, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0; r_dly = 0;
        @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_counters", {txn_count, err_count}, 0);
        @(posedge clk); #1;
        send(1'b0, 32'h0, 32'h0, 4'h0);
        get_rsp(0, w, d, r);
        check("post_rst_txn", txn_count, 1);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
